// File: rtl/am_lock_lane_pkg.sv
// Shared constants for the per-lane alignment-marker lock: period, marker
// patterns and the lock FSM encoding.
package am_pkg;

  localparam int AM_PERIOD  = 16384;
  localparam int CNT_W      = 14;
  localparam int MISS_LIMIT = 4;

  localparam logic [1:0] AM_SYNC = 2'b10;

  // {M0,M1,M2} per logical lane; index k is lane k
  localparam logic [3:0][23:0] LANE_PAT = {24'hA2793D, 24'hC5659B, 24'hF0C4E6, 24'h907647};

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } am_state_e;

endpackage

// File: rtl/am_lock_lane_if.sv
// Block stream into the lane lock stage and the annotated stream out of it.
interface am_lock_lane_if #(
  parameter int CNT_W = 14
) ();

  logic             block_lock;
  logic             in_valid;
  logic [65:0]      data_in;
  logic [65:0]      data_out;
  logic             out_valid;
  logic [CNT_W-1:0] lane_count;
  logic [1:0]       lane_id;
  logic             am_status;

  modport master (
    output block_lock, in_valid, data_in,
    input  data_out, out_valid, lane_count, lane_id, am_status
  );

  modport slave (
    input  block_lock, in_valid, data_in,
    output data_out, out_valid, lane_count, lane_id, am_status
  );

endinterface

// File: rtl/am_lock_lane_match.sv
// Combinational alignment-marker detector: sync header, inverted repeat of
// the marker bytes and one of the four lane patterns. BIP bytes are ignored.
module am_match
  import am_pkg::*;
(
  input  logic [65:0] data_in,
  output logic        is_am,
  output logic [1:0]  am_lane
);

  logic [23:0] m012;
  logic [23:0] m456;
  logic        unused_bip;

  assign unused_bip = ^{data_in[39:32], data_in[7:0]};

  always_comb begin
    m012    = data_in[63:40];
    m456    = data_in[31:8];
    is_am   = 1'b0;
    am_lane = 2'd0;
    if (data_in[65:64] == AM_SYNC && m456 == ~m012) begin
      for (int k = 0; k < 4; k++) begin
        if (m012 == LANE_PAT[k]) begin
          is_am   = 1'b1;
          am_lane = 2'(k);
        end
      end
    end
  end

endmodule

// File: rtl/am_lock_lane.sv
// Per-lane AM lock: hunts for a marker, verifies it one period later, and
// holds lock until MISS_LIMIT consecutive bad markers.
module am_lock_lane #(
  parameter int AM_PERIOD  = am_pkg::AM_PERIOD,
  parameter int CNT_W      = am_pkg::CNT_W,
  parameter int MISS_LIMIT = am_pkg::MISS_LIMIT
) (
  input  logic            clk,
  input  logic            reset,
  am_lock_lane_if.slave   bus
);

  localparam int               MISS_W   = $clog2(MISS_LIMIT + 1);
  localparam logic [CNT_W-1:0] POS_LAST = CNT_W'(AM_PERIOD - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);

  am_pkg::am_state_e state_q, state_d;
  logic [CNT_W-1:0]  pos_q, pos_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic [1:0]        cand_q, cand_d;
  logic [1:0]        lane_id_q, lane_id_d;
  logic [65:0]       data_out_q, data_out_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  lane_count_q, lane_count_d;

  logic              is_am;
  logic [1:0]        am_lane;
  logic [CNT_W-1:0]  blk_pos;
  logic              at_am;
  logic              good_am;

  am_match u_match (
    .data_in (bus.data_in),
    .is_am   (is_am),
    .am_lane (am_lane)
  );

  // blk_pos is the position this block takes once the lane has a candidate;
  // the failing AM that drops lock still reports its own position.
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    miss_d       = miss_q;
    cand_d       = cand_q;
    lane_id_d    = lane_id_q;
    data_out_d   = data_out_q;
    out_valid_d  = bus.in_valid;
    lane_count_d = lane_count_q;
    blk_pos      = pos_q + 1'b1;
    at_am        = (blk_pos == POS_LAST);
    good_am      = is_am && (am_lane == cand_q);

    if (bus.in_valid) begin
      data_out_d = bus.data_in;
    end

    if (!bus.block_lock) begin
      state_d      = am_pkg::HUNT;
      pos_d        = '0;
      miss_d       = '0;
      lane_count_d = '0;
    end else if (bus.in_valid) begin
      unique case (state_q)
        am_pkg::HUNT: begin
          lane_count_d = '0;
          if (is_am) begin
            cand_d  = am_lane;
            pos_d   = POS_LAST;
            state_d = am_pkg::VERIFY;
          end else begin
            pos_d = '0;
          end
        end
        am_pkg::VERIFY: begin
          pos_d        = blk_pos;
          lane_count_d = '0;
          if (at_am) begin
            if (good_am) begin
              state_d      = am_pkg::LOCKED;
              lane_id_d    = cand_q;
              miss_d       = '0;
              lane_count_d = blk_pos;
            end else begin
              state_d = am_pkg::HUNT;
              pos_d   = '0;
            end
          end
        end
        am_pkg::LOCKED: begin
          pos_d        = blk_pos;
          lane_count_d = blk_pos;
          if (at_am) begin
            if (good_am) begin
              miss_d = '0;
            end else if (miss_q == MISS_LAST) begin
              state_d = am_pkg::HUNT;
              pos_d   = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        end
        default: state_d = am_pkg::HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= am_pkg::HUNT;
      pos_q        <= '0;
      miss_q       <= '0;
      cand_q       <= '0;
      lane_id_q    <= '0;
      data_out_q   <= '0;
      out_valid_q  <= 1'b0;
      lane_count_q <= '0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      miss_q       <= miss_d;
      cand_q       <= cand_d;
      lane_id_q    <= lane_id_d;
      data_out_q   <= data_out_d;
      out_valid_q  <= out_valid_d;
      lane_count_q <= lane_count_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.lane_count = lane_count_q;
  assign bus.lane_id    = lane_id_q;
  assign bus.am_status  = (state_q == am_pkg::LOCKED);

endmodule
